time_set_controller: RTL and testbench
======================================

Name: time_set_controller

Overview:
- Button-driven time-setting front end for the time clock.
- Debounces three push buttons (mode, up, down) and walks an edit FSM through hour, minute and second.
- Presents edit values and a blink phase so the display path can flash the selected field.
- Writes the edited time back to the time counter as a one-cycle load strobe. This is the write side of the counter's hour/min/sec interface, which the display path otherwise only reads.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles of the synchronised button level before the debounced level changes (10 ms at 100 MHz).
- BLINK_CYCLES, 25_000_000: half-period of o_blink in clock cycles.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  reset; asynchronous, active-low.
- i_btn_mode  input  1  raw mode button, active-high, asynchronous to i_clk.
- i_btn_up  input  1  raw increment button.
- i_btn_down  input  1  raw decrement button.
- i_hour  input  7  current hour from the counter, 0..23.
- i_min  input  7  current minute, 0..59.
- i_sec  input  7  current second, 0..59.
- o_set_active  output  1  high in any SET state.
- o_field  output  2  0=none, 1=hour, 2=min, 3=sec.
- o_hour  output  7  edit hour.
- o_min  output  7  edit minute.
- o_sec  output  7  edit second.
- o_load  output  1  one-cycle strobe; the counter loads o_hour/o_min/o_sec while it is high.
- o_blink  output  1  1 = show the selected field, 0 = blank it.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; all outputs 0 except o_blink=1; debouncer counters and levels cleared; sync flops 0.
  - Reset mid-edit discards the edits. No o_load is issued.
- Debounce, per button:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level takes the synchronised value once that value has differed from the current level for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press pulse is high for exactly one cycle after the debounced level rises. No pulse on release. Holding a button produces one pulse.
- Press latency: raw rising edge held steady gives the pulse DEBOUNCE_CYCLES+3 cycles later. The FSM acts on the clock edge where the pulse is high.
- FSM states: IDLE, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
  - IDLE + mode pulse: capture i_hour/i_min/i_sec into the edit registers, go to SET_HOUR. up/down are ignored in IDLE.
  - SET_HOUR + mode goes to SET_MIN; SET_MIN + mode goes to SET_SEC; SET_SEC + mode goes to COMMIT.
  - COMMIT: o_load=1 for exactly one cycle, then IDLE unconditionally. Button pulses in COMMIT are ignored.
- Editing in SET_x:
  - up increments the selected field with wrap: hour 23 goes to 0, min/sec 59 goes to 0.
  - down decrements with wrap: 0 goes to 23 or 59.
  - Unselected fields hold.
- Simultaneous pulses:
  - mode with up or down: mode wins, the value is unchanged.
  - up and down together: both ignored.
- o_hour/o_min/o_sec hold the last edit values in IDLE. The counter uses them only when o_load=1.
- o_field is registered and tracks the state (IDLE/COMMIT = 0). o_set_active = (o_field != 0).
- Blink:
  - In SET states, o_blink toggles every BLINK_CYCLES cycles.
  - On every state entry the phase counter clears and o_blink=1.
  - Any up/down pulse also clears the phase and sets o_blink=1, so a changed value is visible immediately.
  - In IDLE/COMMIT o_blink=1.
- Width rule: edit registers are 7 bits. Values above range at capture (not expected) are clamped to 0 on the first up/down.

Decomposition:
- Shared package (time_clock_pkg):
  - field encodings FIELD_NONE/HOUR/MIN/SEC;
  - HOUR_MAX=23, MINSEC_MAX=59;
  - FSM state encoding.
- Sub-module: button_debouncer (synchroniser + stability counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8):
- Debounce and latency:
  - bounce i_btn_mode 1/0 every 2 cycles for 20 cycles -> no state change;
  - then hold it high -> one mode pulse exactly 7 cycles after the last rising edge; state SET_HOUR, o_field=1.
- Capture and wrap:
  - i_hour=23,i_min=59,i_sec=0, press mode then up -> o_hour=0;
  - mode then up -> o_min=0;
  - mode then down -> o_sec=59.
- Commit:
  - from SET_SEC press mode -> o_load high for exactly 1 cycle with the edit values, then IDLE, o_field=0, o_set_active=0.
- Conflicts:
  - up+down pulses in the same cycle in SET_MIN -> o_min unchanged;
  - mode+up in the same cycle -> SET_SEC, o_min unchanged.
- Blink:
  - in SET_HOUR idle -> o_blink period 16 cycles, starting at 1;
  - an up press mid-low-phase -> o_blink=1 the next cycle.
- Reset mid-edit:
  - drop i_reset in SET_MIN -> immediately IDLE, o_load=0, o_blink=1, no load issued after release.

Source files
------------

// File: rtl/time_clock_pkg.sv
// time_clock_pkg: constants and helpers shared by the time-setting front end.
//   - field encodings reported on o_field
//   - range limits for the hour and minute/second fields
//   - edit FSM state encoding
//   - wrap-around increment/decrement helpers for the edit registers
package time_clock_pkg;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   localparam logic [6:0] HOUR_MAX   = 7'd23;
   localparam logic [6:0] MINSEC_MAX = 7'd59;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SET_HOUR = 3'd1;
   localparam logic [2:0] ST_SET_MIN  = 3'd2;
   localparam logic [2:0] ST_SET_SEC  = 3'd3;
   localparam logic [2:0] ST_COMMIT   = 3'd4;

   // Increment with wrap. Anything at or above the limit (including
   // out-of-range captured values) lands on 0.
   function automatic logic [6:0] wrap_inc(input logic [6:0] value,
                                           input logic [6:0] max_value);
      logic [6:0] result;
      if (value >= max_value) begin
         result = 7'd0;
      end else begin
         result = value + 7'd1;
      end
      return result;
   endfunction

   // Decrement with wrap. 0 goes to the limit; out-of-range values clamp to 0.
   function automatic logic [6:0] wrap_dec(input logic [6:0] value,
                                           input logic [6:0] max_value);
      logic [6:0] result;
      if (value == 7'd0) begin
         result = max_value;
      end else if (value > max_value) begin
         result = 7'd0;
      end else begin
         result = value - 7'd1;
      end
      return result;
   endfunction

   // Field shown on the display for a given FSM state.
   function automatic logic [1:0] field_of_state(input logic [2:0] state);
      logic [1:0] result;
      case (state)
         ST_SET_HOUR: result = FIELD_HOUR;
         ST_SET_MIN:  result = FIELD_MIN;
         ST_SET_SEC:  result = FIELD_SEC;
         default:     result = FIELD_NONE;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser, stability counter and press pulse.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   btn    : raw button level, asynchronous to clk
//   pulse  : one-cycle strobe after the debounced level rises
// The debounced level follows the synchronised level only after the two have
// disagreed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the
// count. Raw edge to pulse is DEBOUNCE_CYCLES+3 cycles.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   // Bring the raw button into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

   // Count consecutive cycles of disagreement; commit the new level on the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= {CNT_W{1'b0}};
         level <= 1'b0;
      end else if (sync2 == level) begin
         cnt   <= {CNT_W{1'b0}};
      end else if (cnt == CNT_LAST) begin
         cnt   <= {CNT_W{1'b0}};
         level <= sync2;
      end else begin
         cnt   <= cnt + CNT_ONE;
      end
   end

   // Registered rising-edge detect of the debounced level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d <= 1'b0;
         pulse   <= 1'b0;
      end else begin
         level_d <= level;
         pulse   <= level & ~level_d;
      end
   end

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: button-driven edit front end for the time clock.
//   i_clk, i_reset                  : clock, asynchronous active-low reset
//   i_btn_mode/i_btn_up/i_btn_down  : raw push buttons (active-high)
//   i_hour/i_min/i_sec              : current time, captured on entry to editing
//   o_set_active, o_field           : editing flag and selected field
//   o_hour/o_min/o_sec              : edit values (held after commit)
//   o_load                          : one-cycle load strobe to the time counter
//   o_blink                         : 1 = show selected field, 0 = blank it
module time_set_controller
   import time_clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int BLINK_CYCLES    = 25_000_000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btn_mode,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic [6:0] i_hour,
   input  logic [6:0] i_min,
   input  logic [6:0] i_sec,
   output logic       o_set_active,
   output logic [1:0] o_field,
   output logic [6:0] o_hour,
   output logic [6:0] o_min,
   output logic [6:0] o_sec,
   output logic       o_load,
   output logic       o_blink
);

   localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
   localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

   logic             mode_pulse;
   logic             up_pulse;
   logic             down_pulse;
   logic [2:0]       state;
   logic [2:0]       next_state;
   logic             in_set;
   logic             edit_evt;
   logic [6:0]       hour;
   logic [6:0]       min;
   logic [6:0]       sec;
   logic [1:0]       field;
   logic             set_active;
   logic             load;
   logic             blink;
   logic [BLK_W-1:0] blink_cnt;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
      .clk(i_clk), .rst_n(i_reset), .btn(i_btn_mode), .pulse(mode_pulse));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk(i_clk), .rst_n(i_reset), .btn(i_btn_up), .pulse(up_pulse));
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk(i_clk), .rst_n(i_reset), .btn(i_btn_down), .pulse(down_pulse));

   assign in_set = (state == ST_SET_HOUR) || (state == ST_SET_MIN) || (state == ST_SET_SEC);
   // Mode takes priority over up/down; up and down together cancel.
   assign edit_evt = in_set & ~mode_pulse & (up_pulse ^ down_pulse);

   // Next-state decode of the edit FSM.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (mode_pulse) next_state = ST_SET_HOUR;
            else            next_state = ST_IDLE;
         end
         ST_SET_HOUR: begin
            if (mode_pulse) next_state = ST_SET_MIN;
            else            next_state = ST_SET_HOUR;
         end
         ST_SET_MIN: begin
            if (mode_pulse) next_state = ST_SET_SEC;
            else            next_state = ST_SET_MIN;
         end
         ST_SET_SEC: begin
            if (mode_pulse) next_state = ST_COMMIT;
            else            next_state = ST_SET_SEC;
         end
         ST_COMMIT: next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // State plus the registered outputs derived from the next state.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state      <= ST_IDLE;
         field      <= FIELD_NONE;
         set_active <= 1'b0;
         load       <= 1'b0;
      end else begin
         state      <= next_state;
         field      <= field_of_state(next_state);
         set_active <= (field_of_state(next_state) != FIELD_NONE);
         load       <= (next_state == ST_COMMIT);
      end
   end

   // Edit registers: capture on entry, wrap-edit the selected field.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         hour <= 7'd0;
         min  <= 7'd0;
         sec  <= 7'd0;
      end else if ((state == ST_IDLE) && mode_pulse) begin
         hour <= i_hour;
         min  <= i_min;
         sec  <= i_sec;
      end else if (edit_evt) begin
         case (state)
            ST_SET_HOUR: hour <= up_pulse ? wrap_inc(hour, HOUR_MAX)   : wrap_dec(hour, HOUR_MAX);
            ST_SET_MIN:  min  <= up_pulse ? wrap_inc(min, MINSEC_MAX)  : wrap_dec(min, MINSEC_MAX);
            ST_SET_SEC:  sec  <= up_pulse ? wrap_inc(sec, MINSEC_MAX)  : wrap_dec(sec, MINSEC_MAX);
            default: begin
               hour <= hour;
            end
         endcase
      end else begin
         hour <= hour;
      end
   end

   // Blink phase: restart shown on state change or an edit; steady on outside SET.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         blink_cnt <= {BLK_W{1'b0}};
         blink     <= 1'b1;
      end else if ((field_of_state(next_state) == FIELD_NONE) ||
                   (next_state != state) || edit_evt) begin
         blink_cnt <= {BLK_W{1'b0}};
         blink     <= 1'b1;
      end else if (blink_cnt == BLK_LAST) begin
         blink_cnt <= {BLK_W{1'b0}};
         blink     <= ~blink;
      end else begin
         blink_cnt <= blink_cnt + BLK_ONE;
      end
   end

   assign o_set_active = set_active;
   assign o_field      = field;
   assign o_hour       = hour;
   assign o_min        = min;
   assign o_sec        = sec;
   assign o_load       = load;
   assign o_blink      = blink;

endmodule

// File: tb/tb_time_set_controller.sv
// Testbench for time_set_controller with DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.
module tb_time_set_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic [6:0] cur_hour = 7'd23;
   logic [6:0] cur_min = 7'd59;
   logic [6:0] cur_sec = 7'd0;
   logic       set_active;
   logic [1:0] field;
   logic [6:0] hour;
   logic [6:0] min;
   logic [6:0] sec;
   logic       load;
   logic       blink;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0] btn;     // {mode, up, down}
      logic [1:0] field;
      logic [6:0] hour;
      logic [6:0] min;
      logic [6:0] sec;
   } vec_t;

   vec_t vecs[13];
   vec_t exp_q[$];

   time_set_controller #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
      .i_clk(clk), .i_reset(rst_n),
      .i_btn_mode(btn_mode), .i_btn_up(btn_up), .i_btn_down(btn_down),
      .i_hour(cur_hour), .i_min(cur_min), .i_sec(cur_sec),
      .o_set_active(set_active), .o_field(field),
      .o_hour(hour), .o_min(min), .o_sec(sec),
      .o_load(load), .o_blink(blink));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Hold the buttons long enough for one pulse, then release and let it settle.
   task automatic press(input logic [2:0] mask);
      btn_mode = mask[2];
      btn_up   = mask[1];
      btn_down = mask[0];
      repeat (10) tick();
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      repeat (9) tick();
   endtask

   task automatic run_vectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         vec_t e;
         exp_q.push_back(vecs[i]);
         press(vecs[i].btn);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
         end else begin
            e = exp_q.pop_front();
            check($sformatf("vec%0d_field", i), field, e.field);
            check($sformatf("vec%0d_active", i), set_active, (e.field != 2'd0) ? 1 : 0);
            check($sformatf("vec%0d_hour", i), hour, e.hour);
            check($sformatf("vec%0d_min", i), min, e.min);
            check($sformatf("vec%0d_sec", i), sec, e.sec);
         end
      end
   endtask

   initial begin
      int load_cnt;
      int load_at;
      int exp_blink;

      vecs[0]  = '{3'b010, 2'd1, 7'd0,  7'd59, 7'd0};   // hour 23 -> 0
      vecs[1]  = '{3'b100, 2'd2, 7'd0,  7'd59, 7'd0};
      vecs[2]  = '{3'b010, 2'd2, 7'd0,  7'd0,  7'd0};   // min 59 -> 0
      vecs[3]  = '{3'b100, 2'd3, 7'd0,  7'd0,  7'd0};
      vecs[4]  = '{3'b001, 2'd3, 7'd0,  7'd0,  7'd59};  // sec 0 -> 59
      vecs[5]  = '{3'b010, 2'd0, 7'd0,  7'd0,  7'd59};  // up ignored in IDLE
      vecs[6]  = '{3'b100, 2'd1, 7'd23, 7'd59, 7'd0};   // capture
      vecs[7]  = '{3'b001, 2'd1, 7'd22, 7'd59, 7'd0};
      vecs[8]  = '{3'b100, 2'd2, 7'd22, 7'd59, 7'd0};
      vecs[9]  = '{3'b011, 2'd2, 7'd22, 7'd59, 7'd0};   // up+down cancel
      vecs[10] = '{3'b110, 2'd3, 7'd22, 7'd59, 7'd0};   // mode wins over up
      vecs[11] = '{3'b010, 2'd3, 7'd22, 7'd59, 7'd1};
      vecs[12] = '{3'b100, 2'd0, 7'd22, 7'd59, 7'd1};   // commit, back to IDLE

      // Reset state
      repeat (3) tick();
      check("rst_field", field, 0);
      check("rst_active", set_active, 0);
      check("rst_load", load, 0);
      check("rst_blink", blink, 1);
      check("rst_hour", hour, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Bounce: never stable long enough
      for (int i = 0; i < 5; i++) begin
         btn_mode = 1'b1;
         repeat (2) tick();
         btn_mode = 1'b0;
         repeat (2) tick();
      end
      repeat (6) tick();
      check("bounce_field", field, 0);

      // Steady press: state changes on the edge after the pulse (8th edge)
      btn_mode = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 7) check("latency_early_field", field, 0);
      end
      check("latency_field", field, 1);
      check("latency_active", set_active, 1);
      check("capture_hour", hour, 23);
      repeat (2) tick();
      btn_mode = 1'b0;
      repeat (9) tick();
      check("held_one_pulse_field", field, 1);

      run_vectors(0, 4);

      // Commit: exactly one load cycle carrying the edit values
      load_cnt = 0;
      load_at = -1;
      btn_mode = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (load) begin
            load_cnt++;
            load_at = k;
            check("commit_hour", hour, 0);
            check("commit_min", min, 0);
            check("commit_sec", sec, 59);
            check("commit_field", field, 0);
         end
      end
      check("commit_load_count", load_cnt, 1);
      check("commit_load_cycle", load_at, 8);
      check("commit_idle_field", field, 0);
      check("commit_idle_active", set_active, 0);
      check("commit_idle_blink", blink, 1);
      btn_mode = 1'b0;
      repeat (9) tick();

      run_vectors(5, 12);

      // Blink: period 16 from entry, up press in low phase restarts it
      btn_mode = 1'b1;
      repeat (8) tick();
      check("blink_entry_field", field, 1);
      for (int k = 0; k <= 55; k++) begin
         if (k > 0) tick();
         if (k < 42) exp_blink = ((k / 8) % 2 == 0) ? 1 : 0;
         else        exp_blink = (((k - 42) / 8) % 2 == 0) ? 1 : 0;
         check($sformatf("blink_k%0d", k), blink, exp_blink);
         if (k == 41) check("blink_pre_edit_hour", hour, 23);
         if (k == 42) check("blink_edit_hour", hour, 0);
         if (k == 34) btn_up = 1'b1;
      end
      btn_mode = 1'b0;
      btn_up = 1'b0;
      repeat (9) tick();

      // Reset mid-edit in SET_MIN
      press(3'b100);
      check("pre_reset_field", field, 2);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_field", field, 0);
      check("async_rst_active", set_active, 0);
      check("async_rst_load", load, 0);
      check("async_rst_blink", blink, 1);
      repeat (3) tick();
      rst_n = 1'b1;
      load_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (load) load_cnt++;
      end
      check("post_reset_loads", load_cnt, 0);
      check("post_reset_field", field, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
